conv_window_ctrl: RTL and testbench
===================================

# conv_window_ctrl

Streaming window-position controller for the convolution datapath. It tracks the raster position (row, column, channel) of every accepted input pixel and flags the beats that complete a valid KxK window at the configured stride. It supports a non-square image, interleaved channels, downstream backpressure and frame markers. It sits between the AXI input adapter and the line-buffer/MAC array, and is the parametrised successor of the square, single-channel, stride-only window-valid unit.

## Interface
- IMG_W, 32: image width in pixels (>= KERNEL_SIZE)
- IMG_H, 32: image height in pixels (>= KERNEL_SIZE)
- CHANNELS, 1: channels interleaved per pixel position, channel index fastest
- KERNEL_SIZE, 5: square kernel edge K
- STRIDE, 1: window step in both dimensions (>= 1, any integer)
- Derived: OUT_W = (IMG_W-K)/STRIDE+1, OUT_H = (IMG_H-K)/STRIDE+1; counter widths are $clog2 of each range, minimum 1
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous, active-low
- i_valid  in  1  input pixel beat valid
- i_w_en  in  1  weight-load mode; beats are not pixels and are ignored
- i_clear  in  1  synchronous frame restart; counters go to 0 and the output register is emptied
- o_ready  out  1  block accepts a beat this cycle
- i_out_ready  in  1  downstream accepts the output beat
- o_valid  out  1  output beat valid; one per accepted pixel beat
- o_win_valid  out  1  this beat completes a valid window; qualified by o_valid
- o_out_row  out  $clog2(OUT_H)  output-map row of the completed window
- o_out_col  out  $clog2(OUT_W)  output-map column of the completed window
- o_ch  out  $clog2(CHANNELS)  channel of this beat
- o_sof  out  1  first beat of frame (row 0, col 0, ch 0)
- o_eof  out  1  last beat of frame (row IMG_H-1, col IMG_W-1, ch CHANNELS-1)

## Operation
- Accept = i_valid && o_ready && !i_w_en. o_ready = !o_valid || i_out_ready (single output register, no skid).
- Counters ch, col, row advance only on accept. ch wraps CHANNELS-1 -> 0 and carries to col. col wraps IMG_W-1 -> 0 and carries to row. row wraps IMG_H-1 -> 0 (frame wrap).
- Window condition for input pixel (row r, col c), evaluated before the counters advance:
  - r >= K-1 and c >= K-1
  - (r-(K-1)) divisible by STRIDE and (c-(K-1)) divisible by STRIDE
  - r-(K-1) <= (OUT_H-1)*STRIDE and c-(K-1) <= (OUT_W-1)*STRIDE
- No divide or modulo in RTL. Use stride phase counters per dimension that reset at K-1 and wrap at STRIDE-1, plus output row/col counters that increment on each aligned position.
- o_out_row/o_out_col equal (r-(K-1))/STRIDE and (c-(K-1))/STRIDE on window beats. On non-window beats they hold their last window value.
- All CHANNELS beats of a window position carry o_win_valid=1 with o_ch 0..CHANNELS-1.
- i_w_en=1: no accept, counters hold, the output register still drains.
- i_clear has priority over accept. Counters and phases return to 0 and o_valid drops next cycle. The beat presented in the i_clear cycle is dropped.
- Reset values: all counters 0; o_valid, o_win_valid, o_sof, o_eof 0; o_out_row, o_out_col, o_ch 0.

## Timing
- Latency 1: beat accepted at edge N appears on outputs after edge N. Full throughput is 1 beat/cycle while i_out_ready=1.
- While o_valid && !i_out_ready, all outputs hold stable and o_ready=0.
- Accept and drain in the same cycle are allowed (o_ready=1 when i_out_ready=1).
- Frame wrap is seamless: the beat after the o_eof beat carries o_sof, with no bubble.
- Async reset mid-frame clears immediately. The first accepted beat after deassertion is row 0, col 0 with o_sof=1.

## Test plan
- Defaults (32x32, K5, S1, C1), 1024 back-to-back beats -> first o_win_valid on beat 132 (r4, c4) with out (0,0); 784 window beats; last window at beat 1023 with out (27,27); o_eof on beat 1023.
- IMG 8x8, K3, S2 -> windows only at r,c in {2,4,6}, 9 total, out coords 0..2. IMG 9x9, K3, S2 -> r,c in {2,4,6,8}, 16 total.
- IMG_W=10, IMG_H=6, K3, S1, CHANNELS=3 -> each window position gives 3 consecutive o_win_valid beats with o_ch 0,1,2; 8x4 positions, 96 window beats; o_eof on beat 179.
- Random i_out_ready (50%) over two frames -> outputs stable while stalled, no beat lost or duplicated, o_sof of frame 2 directly follows o_eof of frame 1.
- i_w_en=1 for 10 cycles mid-row with i_valid=1 -> o_ready behaviour unchanged, counters frozen, next pixel continues at the same col.
- i_clear at r3 c7, then rst_n pulse at r5 c2 -> next accepted beat after each has o_sof=1 and row/col 0; no stale o_valid.

Source files
------------

// File: rtl/conv_window_ctrl.sv
// ---------------------------------------------------------------------------
// conv_window_ctrl
//
// Streaming window-position controller for the convolution datapath. Tracks
// the raster position (row, column, channel) of every accepted pixel beat and
// flags the beats that complete a valid KERNEL_SIZE x KERNEL_SIZE window at
// the configured STRIDE. Channels are interleaved per pixel position with the
// channel index running fastest. One output register, no skid buffer.
//
// Ports
//   clk          clock, all state updates on the rising edge
//   rst_n        asynchronous active-low reset
//   i_valid      input pixel beat valid
//   i_w_en       weight-load mode: beats are not pixels and are ignored
//   i_clear      synchronous frame restart (counters to 0, output emptied)
//   o_ready      block accepts a beat this cycle
//   i_out_ready  downstream accepts the output beat
//   o_valid      output beat valid, one per accepted pixel beat
//   o_win_valid  beat completes a valid window (qualified by o_valid)
//   o_out_row    output-map row of the last completed window
//   o_out_col    output-map column of the last completed window
//   o_ch         channel index of this beat
//   o_sof        first beat of frame
//   o_eof        last beat of frame
// ---------------------------------------------------------------------------
module conv_window_ctrl #(
    parameter int unsigned IMG_W       = 32,
    parameter int unsigned IMG_H       = 32,
    parameter int unsigned CHANNELS    = 1,
    parameter int unsigned KERNEL_SIZE = 5,
    parameter int unsigned STRIDE      = 1,
    localparam int unsigned OUT_W  = (IMG_W - KERNEL_SIZE) / STRIDE + 1,
    localparam int unsigned OUT_H  = (IMG_H - KERNEL_SIZE) / STRIDE + 1,
    localparam int unsigned OROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1,
    localparam int unsigned OCOL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1,
    localparam int unsigned CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_valid,
    input  logic              i_w_en,
    input  logic              i_clear,
    output logic              o_ready,
    input  logic              i_out_ready,
    output logic              o_valid,
    output logic              o_win_valid,
    output logic [OROW_W-1:0] o_out_row,
    output logic [OCOL_W-1:0] o_out_col,
    output logic [CH_W-1:0]   o_ch,
    output logic              o_sof,
    output logic              o_eof
);

    localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int unsigned PH_W  = (STRIDE > 1) ? $clog2(STRIDE) : 1;

    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [CH_W-1:0]   CH_LAST  = CH_W'(CHANNELS - 1);
    localparam logic [ROW_W-1:0]  ROW_KM1  = ROW_W'(KERNEL_SIZE - 1);
    localparam logic [COL_W-1:0]  COL_KM1  = COL_W'(KERNEL_SIZE - 1);
    localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(STRIDE - 1);

    localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [CH_W-1:0]   CH_ONE   = CH_W'(1);
    localparam logic [PH_W-1:0]   PH_ONE   = PH_W'(1);
    localparam logic [OROW_W-1:0] OROW_ONE = OROW_W'(1);
    localparam logic [OCOL_W-1:0] OCOL_ONE = OCOL_W'(1);

    // Raster position of the next pixel beat to be accepted
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [CH_W-1:0]   r_ch;

    // Stride phase of (pos-(K-1)) and index of the current/last aligned
    // position in each dimension; both are 0 while pos < K-1.
    logic [PH_W-1:0]   r_row_ph;
    logic [PH_W-1:0]   r_col_ph;
    logic [OROW_W-1:0] r_row_idx;
    logic [OCOL_W-1:0] r_col_idx;

    // Output register
    logic              r_valid;
    logic              r_win;
    logic [OROW_W-1:0] r_out_row;
    logic [OCOL_W-1:0] r_out_col;
    logic [CH_W-1:0]   r_och;
    logic              r_sof;
    logic              r_eof;

    logic              w_ready;
    logic              w_accept;
    logic              w_ch_wrap;
    logic              w_col_wrap;
    logic              w_row_wrap;
    logic              w_row_in;
    logic              w_col_in;
    logic              w_win;
    logic              w_sof;
    logic              w_eof;

    logic [CH_W-1:0]   w_ch_nxt;
    logic [COL_W-1:0]  w_col_nxt;
    logic [ROW_W-1:0]  w_row_nxt;
    logic [PH_W-1:0]   w_col_ph_nxt;
    logic [PH_W-1:0]   w_row_ph_nxt;
    logic [OCOL_W-1:0] w_col_idx_nxt;
    logic [OROW_W-1:0] w_row_idx_nxt;

    assign w_ready  = !r_valid || i_out_ready;
    assign w_accept = i_valid && w_ready && !i_w_en;

    assign w_ch_wrap  = (r_ch == CH_LAST);
    assign w_col_wrap = (r_col == COL_LAST);
    assign w_row_wrap = (r_row == ROW_LAST);

    // The upper bound on the window position needs no compare: the largest
    // aligned index reachable inside the image is exactly OUT_x-1.
    assign w_col_in = (r_col >= COL_KM1) && (r_col_ph == '0);
    assign w_row_in = (r_row >= ROW_KM1) && (r_row_ph == '0);
    assign w_win    = w_col_in && w_row_in;

    assign w_sof = (r_row == '0) && (r_col == '0) && (r_ch == '0);
    assign w_eof = w_row_wrap && w_col_wrap && w_ch_wrap;

    always_comb begin
        w_ch_nxt      = w_ch_wrap  ? '0 : r_ch  + CH_ONE;
        w_col_nxt     = w_col_wrap ? '0 : r_col + COL_ONE;
        w_row_nxt     = w_row_wrap ? '0 : r_row + ROW_ONE;

        w_col_ph_nxt  = r_col_ph;
        w_col_idx_nxt = r_col_idx;
        if (w_col_wrap || (r_col < COL_KM1)) begin
            w_col_ph_nxt  = '0;
            w_col_idx_nxt = '0;
        end else if (r_col_ph == PH_LAST) begin
            w_col_ph_nxt  = '0;
            w_col_idx_nxt = r_col_idx + OCOL_ONE;
        end else begin
            w_col_ph_nxt  = r_col_ph + PH_ONE;
        end

        w_row_ph_nxt  = r_row_ph;
        w_row_idx_nxt = r_row_idx;
        if (w_row_wrap || (r_row < ROW_KM1)) begin
            w_row_ph_nxt  = '0;
            w_row_idx_nxt = '0;
        end else if (r_row_ph == PH_LAST) begin
            w_row_ph_nxt  = '0;
            w_row_idx_nxt = r_row_idx + OROW_ONE;
        end else begin
            w_row_ph_nxt  = r_row_ph + PH_ONE;
        end
    end

    // Position counters: channel carries into column, column into row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_row     <= '0;
            r_col     <= '0;
            r_ch      <= '0;
            r_row_ph  <= '0;
            r_col_ph  <= '0;
            r_row_idx <= '0;
            r_col_idx <= '0;
        end else if (i_clear) begin
            r_row     <= '0;
            r_col     <= '0;
            r_ch      <= '0;
            r_row_ph  <= '0;
            r_col_ph  <= '0;
            r_row_idx <= '0;
            r_col_idx <= '0;
        end else if (w_accept) begin
            r_ch <= w_ch_nxt;
            if (w_ch_wrap) begin
                r_col     <= w_col_nxt;
                r_col_ph  <= w_col_ph_nxt;
                r_col_idx <= w_col_idx_nxt;
                if (w_col_wrap) begin
                    r_row     <= w_row_nxt;
                    r_row_ph  <= w_row_ph_nxt;
                    r_row_idx <= w_row_idx_nxt;
                end
            end
        end
    end

    // Output register: load on accept, otherwise empty when drained.
    // Window coordinates only move on window beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid   <= 1'b0;
            r_win     <= 1'b0;
            r_out_row <= '0;
            r_out_col <= '0;
            r_och     <= '0;
            r_sof     <= 1'b0;
            r_eof     <= 1'b0;
        end else if (i_clear) begin
            r_valid   <= 1'b0;
            r_win     <= 1'b0;
            r_out_row <= '0;
            r_out_col <= '0;
            r_och     <= '0;
            r_sof     <= 1'b0;
            r_eof     <= 1'b0;
        end else if (w_accept) begin
            r_valid <= 1'b1;
            r_win   <= w_win;
            r_och   <= r_ch;
            r_sof   <= w_sof;
            r_eof   <= w_eof;
            if (w_win) begin
                r_out_row <= r_row_idx;
                r_out_col <= r_col_idx;
            end
        end else if (i_out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_ready     = w_ready;
    assign o_valid     = r_valid;
    assign o_win_valid = r_win;
    assign o_out_row   = r_out_row;
    assign o_out_col   = r_out_col;
    assign o_ch        = r_och;
    assign o_sof       = r_sof;
    assign o_eof       = r_eof;

endmodule

// File: tb/tb_conv_window_ctrl.sv
// ---------------------------------------------------------------------------
// tb_conv_window_ctrl
//
// Four instances of conv_window_ctrl share one stimulus bus:
//   0: 32x32, K5, S1, C1     1: 8x8, K3, S2, C1
//   2: 9x9,   K3, S2, C1     3: 10x6 (WxH), K3, S1, C3
// One instance is observed at a time through an output mux. Every test
// starts from a reset or clear so the unobserved instances never matter.
// ---------------------------------------------------------------------------
module tb_conv_window_ctrl;

    logic clk = 1'b0;
    logic rst_n;
    logic i_valid;
    logic i_w_en;
    logic i_clear;
    logic i_out_ready;

    always #5 clk = ~clk;

    logic       d0_ready, d0_valid, d0_win, d0_sof, d0_eof;
    logic [4:0] d0_row, d0_col;
    logic [0:0] d0_ch;
    logic       d1_ready, d1_valid, d1_win, d1_sof, d1_eof;
    logic [1:0] d1_row, d1_col;
    logic [0:0] d1_ch;
    logic       d2_ready, d2_valid, d2_win, d2_sof, d2_eof;
    logic [1:0] d2_row, d2_col;
    logic [0:0] d2_ch;
    logic       d3_ready, d3_valid, d3_win, d3_sof, d3_eof;
    logic [1:0] d3_row;
    logic [2:0] d3_col;
    logic [1:0] d3_ch;

    conv_window_ctrl #(.IMG_W(32), .IMG_H(32), .CHANNELS(1), .KERNEL_SIZE(5), .STRIDE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_w_en(i_w_en), .i_clear(i_clear),
        .o_ready(d0_ready), .i_out_ready(i_out_ready), .o_valid(d0_valid), .o_win_valid(d0_win),
        .o_out_row(d0_row), .o_out_col(d0_col), .o_ch(d0_ch), .o_sof(d0_sof), .o_eof(d0_eof));

    conv_window_ctrl #(.IMG_W(8), .IMG_H(8), .CHANNELS(1), .KERNEL_SIZE(3), .STRIDE(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_w_en(i_w_en), .i_clear(i_clear),
        .o_ready(d1_ready), .i_out_ready(i_out_ready), .o_valid(d1_valid), .o_win_valid(d1_win),
        .o_out_row(d1_row), .o_out_col(d1_col), .o_ch(d1_ch), .o_sof(d1_sof), .o_eof(d1_eof));

    conv_window_ctrl #(.IMG_W(9), .IMG_H(9), .CHANNELS(1), .KERNEL_SIZE(3), .STRIDE(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_w_en(i_w_en), .i_clear(i_clear),
        .o_ready(d2_ready), .i_out_ready(i_out_ready), .o_valid(d2_valid), .o_win_valid(d2_win),
        .o_out_row(d2_row), .o_out_col(d2_col), .o_ch(d2_ch), .o_sof(d2_sof), .o_eof(d2_eof));

    conv_window_ctrl #(.IMG_W(10), .IMG_H(6), .CHANNELS(3), .KERNEL_SIZE(3), .STRIDE(1)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_w_en(i_w_en), .i_clear(i_clear),
        .o_ready(d3_ready), .i_out_ready(i_out_ready), .o_valid(d3_valid), .o_win_valid(d3_win),
        .o_out_row(d3_row), .o_out_col(d3_col), .o_ch(d3_ch), .o_sof(d3_sof), .o_eof(d3_eof));

    // Configuration table, same order as the instances
    int cfg_w [4] = '{32, 8, 9, 10};
    int cfg_h [4] = '{32, 8, 9, 6};
    int cfg_c [4] = '{1, 1, 1, 3};
    int cfg_k [4] = '{5, 3, 3, 3};
    int cfg_s [4] = '{1, 2, 2, 1};

    int sel;
    logic       m_ready, m_valid, m_win, m_sof, m_eof;
    logic [7:0] m_row, m_col, m_ch;

    always_comb begin
        m_ready = 1'b0; m_valid = 1'b0; m_win = 1'b0; m_sof = 1'b0; m_eof = 1'b0;
        m_row = '0; m_col = '0; m_ch = '0;
        case (sel)
            0: begin
                m_ready = d0_ready; m_valid = d0_valid; m_win = d0_win; m_sof = d0_sof; m_eof = d0_eof;
                m_row = 8'(d0_row); m_col = 8'(d0_col); m_ch = 8'(d0_ch);
            end
            1: begin
                m_ready = d1_ready; m_valid = d1_valid; m_win = d1_win; m_sof = d1_sof; m_eof = d1_eof;
                m_row = 8'(d1_row); m_col = 8'(d1_col); m_ch = 8'(d1_ch);
            end
            2: begin
                m_ready = d2_ready; m_valid = d2_valid; m_win = d2_win; m_sof = d2_sof; m_eof = d2_eof;
                m_row = 8'(d2_row); m_col = 8'(d2_col); m_ch = 8'(d2_ch);
            end
            default: begin
                m_ready = d3_ready; m_valid = d3_valid; m_win = d3_win; m_sof = d3_sof; m_eof = d3_eof;
                m_row = 8'(d3_row); m_col = 8'(d3_col); m_ch = 8'(d3_ch);
            end
        endcase
    end

    int n_checks;
    int n_fails;

    // Per-stream statistics gathered from the observed outputs
    int n_win, first_win, last_win, last_wrc;
    int n_sof, sof_idx, n_eof, eof_idx;
    int cyc;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // {win, sof, eof, 5'b0, ch, out_row, out_col}
    function automatic logic [31:0] pack_now();
        return {m_win, m_sof, m_eof, 5'd0, m_ch, m_row, m_col};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        i_valid = 1'b0; i_w_en = 1'b0; i_clear = 1'b0; i_out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Streams nb pixel beats into instance s, checking every output beat
    // against a divide/modulo reference, o_ready every cycle, and output
    // stability across stalls. wen_at < 0 disables the weight-load burst.
    task automatic stream(input int s, input int nb, input int rdy_pct,
                          input int wen_at, input int wen_len, output int cycles);
        int sent, got, wen_left, lrow, lcol;
        int W, H, C, K, S, ow, oh, chn, pix, c, r;
        bit wen_done, stalled, rdy, wen, exp_rdy, win_b, sof_b, eof_b;
        logic [31:0] snap, exp;
        sel = s;
        W = cfg_w[s]; H = cfg_h[s]; C = cfg_c[s]; K = cfg_k[s]; S = cfg_s[s];
        ow = (W - K) / S + 1; oh = (H - K) / S + 1;
        sent = 0; got = 0; wen_left = 0; wen_done = 0; stalled = 0;
        lrow = 0; lcol = 0; cycles = 0; snap = '0;
        n_win = 0; first_win = -1; last_win = -1; last_wrc = -1;
        n_sof = 0; sof_idx = -1; n_eof = 0; eof_idx = -1;
        while (got < nb && cycles < 20000) begin
            @(negedge clk);
            if (stalled) check_eq("stall_hold", pack_now(), snap);
            rdy = ($urandom_range(99) < rdy_pct);
            wen = 1'b0;
            if (!wen_done && wen_at >= 0 && sent == wen_at) begin
                wen_left = wen_len;
                wen_done = 1'b1;
            end
            if (wen_left > 0) begin
                wen = 1'b1;
                wen_left--;
            end
            i_out_ready = rdy; i_w_en = wen; i_clear = 1'b0;
            i_valid = (sent < nb);
            #1;
            exp_rdy = !m_valid || rdy;
            check_eq("o_ready", 32'(m_ready), 32'(exp_rdy));
            if (m_valid && rdy) begin
                chn = got % C; pix = got / C; c = pix % W; r = (pix / W) % H;
                win_b = (r >= K - 1) && (c >= K - 1) &&
                        ((r - (K - 1)) % S == 0) && ((c - (K - 1)) % S == 0) &&
                        ((r - (K - 1)) / S <= oh - 1) && ((c - (K - 1)) / S <= ow - 1);
                if (win_b) begin
                    lrow = (r - (K - 1)) / S;
                    lcol = (c - (K - 1)) / S;
                end
                sof_b = (r == 0) && (c == 0) && (chn == 0);
                eof_b = (r == H - 1) && (c == W - 1) && (chn == C - 1);
                exp = {win_b, sof_b, eof_b, 5'd0, chn[7:0], lrow[7:0], lcol[7:0]};
                check_eq("beat", pack_now(), exp);
                if (m_win) begin
                    n_win++;
                    if (first_win < 0) first_win = got;
                    last_win = got;
                    last_wrc = {16'd0, m_row, m_col};
                end
                if (m_sof) begin n_sof++; sof_idx = got; end
                if (m_eof) begin n_eof++; eof_idx = got; end
                got++;
            end
            stalled = m_valid && !rdy;
            snap = pack_now();
            if (i_valid && exp_rdy && !wen) sent++;
            cycles++;
        end
        if (got < nb) check_eq("stream_timeout", 32'(got), 32'(nb));
        @(negedge clk);
        i_valid = 1'b0; i_w_en = 1'b0; i_out_ready = 1'b1;
        #1;
        check_eq("drained", 32'(m_valid), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0; n_fails = 0; sel = 0;
        rst_n = 1'b0; i_valid = 1'b0; i_w_en = 1'b0; i_clear = 1'b0; i_out_ready = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state of every instance
        for (int s = 0; s < 4; s++) begin
            sel = s;
            #1;
            check_eq("rst_valid", 32'(m_valid), 32'd0);
            check_eq("rst_fields", pack_now(), 32'd0);
            check_eq("rst_ready", 32'(m_ready), 32'd1);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // 32x32 K5 S1, one back-to-back frame
        stream(0, 1024, 100, -1, 0, cyc);
        check_eq("d0_cycles", 32'(cyc), 32'd1025);
        check_eq("d0_nwin", 32'(n_win), 32'd784);
        check_eq("d0_first_win", 32'(first_win), 32'd132);
        check_eq("d0_last_win", 32'(last_win), 32'd1023);
        check_eq("d0_last_rc", 32'(last_wrc), {16'd0, 8'd27, 8'd27});
        check_eq("d0_eof_idx", 32'(eof_idx), 32'd1023);
        check_eq("d0_nsof", 32'(n_sof), 32'd1);

        // 8x8 K3 S2
        do_reset();
        stream(1, 64, 100, -1, 0, cyc);
        check_eq("d1_nwin", 32'(n_win), 32'd9);
        check_eq("d1_first_win", 32'(first_win), 32'd18);
        check_eq("d1_last_win", 32'(last_win), 32'd54);
        check_eq("d1_last_rc", 32'(last_wrc), {16'd0, 8'd2, 8'd2});
        check_eq("d1_eof_idx", 32'(eof_idx), 32'd63);

        // 9x9 K3 S2
        do_reset();
        stream(2, 81, 100, -1, 0, cyc);
        check_eq("d2_nwin", 32'(n_win), 32'd16);
        check_eq("d2_first_win", 32'(first_win), 32'd20);
        check_eq("d2_last_win", 32'(last_win), 32'd80);
        check_eq("d2_last_rc", 32'(last_wrc), {16'd0, 8'd3, 8'd3});

        // 10x6 K3 S1, 3 channels
        do_reset();
        stream(3, 180, 100, -1, 0, cyc);
        check_eq("d3_nwin", 32'(n_win), 32'd96);
        check_eq("d3_first_win", 32'(first_win), 32'd66);
        check_eq("d3_last_win", 32'(last_win), 32'd179);
        check_eq("d3_last_rc", 32'(last_wrc), {16'd0, 8'd3, 8'd7});
        check_eq("d3_eof_idx", 32'(eof_idx), 32'd179);

        // Two 8x8 frames at full rate: frame wrap has no bubble
        do_reset();
        stream(1, 128, 100, -1, 0, cyc);
        check_eq("wrap_cycles", 32'(cyc), 32'd129);
        check_eq("wrap_nsof", 32'(n_sof), 32'd2);
        check_eq("wrap_sof2_idx", 32'(sof_idx), 32'd64);
        check_eq("wrap_eof2_idx", 32'(eof_idx), 32'd127);
        check_eq("wrap_nwin", 32'(n_win), 32'd18);

        // Two 10x6x3 frames with 50% downstream backpressure
        do_reset();
        stream(3, 360, 50, -1, 0, cyc);
        check_eq("bp_nwin", 32'(n_win), 32'd192);
        check_eq("bp_nsof", 32'(n_sof), 32'd2);
        check_eq("bp_sof2_idx", 32'(sof_idx), 32'd180);
        check_eq("bp_neof", 32'(n_eof), 32'd2);
        check_eq("bp_eof2_idx", 32'(eof_idx), 32'd359);

        // Weight-load burst of 10 cycles at row 1 col 8
        do_reset();
        stream(0, 100, 100, 40, 10, cyc);
        check_eq("wen_cycles", 32'(cyc), 32'd111);

        // i_clear presented with pixel r3 c7 while r3 c6 is stalled in the output
        do_reset();
        stream(0, 102, 100, -1, 0, cyc);
        i_valid = 1'b1; i_out_ready = 1'b0;
        @(negedge clk);
        check_eq("pre_clear_valid", 32'(m_valid), 32'd1);
        i_clear = 1'b1; i_valid = 1'b1; i_out_ready = 1'b0;
        #1;
        check_eq("clear_ready", 32'(m_ready), 32'd0);
        @(negedge clk);
        check_eq("clear_empties", 32'(m_valid), 32'd0);
        i_clear = 1'b0; i_valid = 1'b0; i_out_ready = 1'b1;
        stream(0, 40, 100, -1, 0, cyc);
        check_eq("clear_nsof", 32'(n_sof), 32'd1);
        check_eq("clear_sof_idx", 32'(sof_idx), 32'd0);

        // Asynchronous reset mid-cycle with pixel r5 c2 held in the output
        do_reset();
        stream(0, 162, 100, -1, 0, cyc);
        i_valid = 1'b1; i_out_ready = 1'b0;
        @(negedge clk);
        check_eq("pre_rst_valid", 32'(m_valid), 32'd1);
        i_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("async_rst_valid", 32'(m_valid), 32'd0);
        check_eq("async_rst_fields", pack_now(), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        i_out_ready = 1'b1;
        stream(0, 40, 100, -1, 0, cyc);
        check_eq("rst_nsof", 32'(n_sof), 32'd1);
        check_eq("rst_sof_idx", 32'(sof_idx), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
